// File: rtl/box_plotter.sv
// Box rasterizer for the player drawing interface: clears the 160x120 screen after reset,
// then turns each queued (x, y, colour) request into BOX_W x BOX_H single-pixel VGA writes.
module box_plotter #(
  parameter int unsigned BOX_W = 4,
  parameter int unsigned BOX_H = 8,
  parameter int unsigned SCR_W = 160,
  parameter int unsigned SCR_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       clear_done
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_DRAW} state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } req_t;

  localparam logic [7:0] CLR_X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0] CLR_Y_LAST = 7'(SCR_H - 1);
  localparam logic [7:0] CX_LAST    = 8'(BOX_W - 1);
  localparam logic [6:0] CY_LAST    = 7'(BOX_H - 1);
  localparam logic [8:0] X_LIMIT    = 9'(SCR_W);
  localparam logic [7:0] Y_LIMIT    = 8'(SCR_H);

  // ---------------------------------------------------------------------------
  // Two-entry request FIFO
  // ---------------------------------------------------------------------------
  req_t       fifo_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       push, pop;
  req_t       head;

  state_e     state_q, state_d;

  assign req_ready = (count_q != 2'd2);
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != 2'd0);
  assign head      = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage needs no reset; an entry is only read after count_q says it was written.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{x: req_x, y: req_y, colour: req_colour};
  end

  // ---------------------------------------------------------------------------
  // Sweep / draw FSM with registered pixel outputs
  // ---------------------------------------------------------------------------
  logic [7:0] clr_x_q, clr_x_d;
  logic [6:0] clr_y_q, clr_y_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [2:0] base_c_q, base_c_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_c_q, vga_c_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  // Box pixel position is kept one bit wider so off-screen pixels can be clipped.
  assign sum_x = {1'b0, base_x_q} + {1'b0, cx_q};
  assign sum_y = {1'b0, base_y_q} + {1'b0, cy_q};

  // NOTE: every always_comb output gets a hold/default value first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    clr_x_d  = clr_x_q;
    clr_y_d  = clr_y_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    base_c_d = base_c_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    vga_c_d  = vga_c_q;
    plot_d   = 1'b0;
    done_d   = done_q;

    case (state_q)
      S_CLEAR: begin
        plot_d  = 1'b1;
        vga_x_d = clr_x_q;
        vga_y_d = clr_y_q;
        vga_c_d = 3'd0;
        if (clr_x_q == CLR_X_LAST) begin
          clr_x_d = 8'd0;
          if (clr_y_q == CLR_Y_LAST) begin
            clr_y_d = 7'd0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            clr_y_d = clr_y_q + 7'd1;
          end
        end else begin
          clr_x_d = clr_x_q + 8'd1;
        end
      end

      S_IDLE: begin
        if (pop) begin
          base_x_d = head.x;
          base_y_d = head.y;
          base_c_d = head.colour;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        cx_d    = 8'd0;
        cy_d    = 7'd0;
        state_d = S_DRAW;
      end

      S_DRAW: begin
        vga_x_d = sum_x[7:0];
        vga_y_d = sum_y[6:0];
        vga_c_d = base_c_q;
        plot_d  = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
        if (cx_q == CX_LAST) begin
          cx_d = 8'd0;
          if (cy_q == CY_LAST) begin
            cy_d    = 7'd0;
            state_d = S_IDLE;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      default: state_d = S_CLEAR;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q  <= S_CLEAR;
      clr_x_q  <= 8'd0;
      clr_y_q  <= 7'd0;
      base_x_q <= 8'd0;
      base_y_q <= 7'd0;
      base_c_q <= 3'd0;
      cx_q     <= 8'd0;
      cy_q     <= 7'd0;
      vga_x_q  <= 8'd0;
      vga_y_q  <= 7'd0;
      vga_c_q  <= 3'd0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_x_q  <= clr_x_d;
      clr_y_q  <= clr_y_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      base_c_q <= base_c_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      vga_x_q  <= vga_x_d;
      vga_y_q  <= vga_y_d;
      vga_c_q  <= vga_c_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_c_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_box_plotter.sv
// Directed bench for box_plotter: screen clear sweep, single/queued boxes, clipping,
// requests during clear and reset while drawing with a request pending.
module tb_box_plotter;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x = 8'd0;
  logic [6:0] req_y = 7'd0;
  logic [2:0] req_colour = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       clear_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  box_plotter dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .clear_done (clear_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_valid  = 1'b1;
    req_x      = x;
    req_y      = y;
    req_colour = c;
  endtask

  // Full 19200-pixel sweep; optionally offers one request partway through.
  task automatic sweep(input string tag, input bit inject);
    int errs;
    int ex, ey;
    errs = 0;
    for (int i = 0; i < 160 * 120; i++) begin
      if (inject && i == 50) begin
        check({tag, "_rdy_in_clear"}, req_ready, 1);
        set_req(8'd10, 7'd20, 3'b010);
      end
      step();
      if (inject && i == 50) req_valid = 1'b0;
      ex = i % 160;
      ey = i / 160;
      if (plot !== 1'b1 || vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== 3'd0)
        errs++;
    end
    check({tag, "_sweep_errs"}, errs, 0);
  endtask

  // Checks n consecutive DRAW cycles of a box anchored at (bx, by).
  task automatic box(input string tag, input int bx, input int by, input logic [2:0] col,
                     input int n, input int exp_plots);
    int errs, plots, ex, ey;
    logic ep;
    errs  = 0;
    plots = 0;
    for (int i = 0; i < n; i++) begin
      step();
      ex = bx + i % 4;
      ey = by + i / 4;
      ep = (ex < 160) && (ey < 120);
      if (plot === 1'b1) plots++;
      if (plot !== ep || vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== col)
        errs++;
    end
    check({tag, "_px_errs"}, errs, 0);
    check({tag, "_plots"}, plots, exp_plots);
  endtask

  initial begin
    int plots;

    // Reset values
    resetn = 1'b1;
    step();
    step();
    check("rst_plot", plot, 0);
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_busy", busy, 1);
    check("rst_done", clear_done, 0);
    check("rst_ready", req_ready, 1);
    resetn = 1'b0;

    // Clear sweep, then idle
    sweep("clr0", 1'b0);
    step();
    check("clr0_plot_off", plot, 0);
    check("clr0_done", clear_done, 1);
    check("clr0_busy", busy, 0);

    // Single box, 3-edge latency
    set_req(8'd38, 7'd100, 3'b100);
    check("b1_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("b1_lat1", plot, 0);
    step();
    check("b1_lat2", plot, 0);
    check("b1_busy_load", busy, 1);
    step();
    check("b1_lat3", plot, 0);
    box("b1", 38, 100, 3'b100, 32, 32);
    step();
    check("b1_after_plot", plot, 0);
    check("b1_after_busy", busy, 0);

    // Three queued boxes, valid held high
    set_req(8'd43, 7'd100, 3'b100);
    step();
    set_req(8'd38, 7'd88, 3'b100);
    step();
    set_req(8'd38, 7'd76, 3'b100);
    check("q_ready_one", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("q_ready_full", req_ready, 0);
    check("q_plot_load", plot, 0);
    box("qa", 43, 100, 3'b100, 32, 32);
    step();
    check("qa_gap_idle", plot, 0);
    check("q_ready_after_pop", req_ready, 1);
    step();
    check("qa_gap_load", plot, 0);
    box("qb", 38, 88, 3'b100, 32, 32);
    step();
    check("qb_gap_idle", plot, 0);
    step();
    check("qb_gap_load", plot, 0);
    box("qc", 38, 76, 3'b100, 32, 32);
    step();
    check("qc_after_plot", plot, 0);
    check("qc_after_busy", busy, 0);

    // Corner box, clipped to 4 visible pixels
    set_req(8'd158, 7'd118, 3'b001);
    step();
    req_valid = 1'b0;
    step();
    step();
    box("clip", 158, 118, 3'b001, 32, 4);
    step();
    check("clip_after_plot", plot, 0);

    // Request during clear, drawn only afterwards
    resetn = 1'b1;
    step();
    check("rst2_plot", plot, 0);
    check("rst2_busy", busy, 1);
    check("rst2_done", clear_done, 0);
    resetn = 1'b0;
    sweep("clr1", 1'b1);
    step();
    check("clr1_done", clear_done, 1);
    check("clr1_idle_plot", plot, 0);
    step();
    check("clr1_load_plot", plot, 0);
    box("pend", 10, 20, 3'b010, 32, 32);

    // Reset on the 10th pixel with one request pending
    set_req(8'd50, 7'd50, 3'b111);
    step();
    set_req(8'd60, 7'd60, 3'b011);
    step();
    req_valid = 1'b0;
    step();
    box("part", 50, 50, 3'b111, 10, 10);
    resetn = 1'b1;
    step();
    check("rst3_plot", plot, 0);
    check("rst3_busy", busy, 1);
    check("rst3_done", clear_done, 0);
    check("rst3_vga_x", vga_x, 0);
    check("rst3_ready", req_ready, 1);
    resetn = 1'b0;
    sweep("clr2", 1'b0);
    step();
    check("clr2_plot_off", plot, 0);
    check("clr2_busy", busy, 0);
    plots = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (plot === 1'b1) plots++;
    end
    check("discarded_plots", plots, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
